// File: rtl/ecc_err_monitor.sv
// ECC error monitor: counts decoder single/double-bit/repair events, tracks a health FSM, raises irq.
// Latency: every sampled event shows on the registered outputs one cycle later; no backpressure.
// Optional syndrome logging (first/last syndrome) is built only when ECC_ERR_MONITOR_SYNLOG_EN is defined.
module ecc_err_monitor #(
    parameter int SW        = 8,
    parameter int CNT_W     = 16,
    parameter int SB_THRESH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clkena_i,
    input  logic             valid_i,
    input  logic             sb_err_i,
    input  logic             db_err_i,
    input  logic             sb_fix_i,
    input  logic [SW-1:0]    syndrome_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic [CNT_W-1:0] fix_cnt_o,
    output logic [1:0]       state_o,
    output logic             irq_o,
    output logic             syn_vld_o,
    output logic [SW-1:0]    syn_first_o,
    output logic [SW-1:0]    syn_last_o
);

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_CORR   = 2'd1,
        ST_THRESH = 2'd2,
        ST_FATAL  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(SB_THRESH);

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    state_e           state_q, state_d;
    logic             irq_q;
    logic [CNT_W-1:0] sb_cnt_q, db_cnt_q, fix_cnt_q;
    logic [CNT_W-1:0] sb_cnt_d, db_cnt_d, fix_cnt_d;
    logic [CNT_W-1:0] sb_base, db_base, fix_base;
    state_e           st_base;

    // A double-bit flag dominates: a cycle with both flags is only a double-bit event.
    logic take, sb_ev, db_ev, fix_ev, err_ev;
    assign take   = clkena_i & valid_i;
    assign db_ev  = take & db_err_i;
    assign sb_ev  = take & sb_err_i & ~db_err_i;
    assign fix_ev = sb_ev & sb_fix_i;
    assign err_ev = sb_ev | db_ev;

    // Clear is applied first, then the same-cycle event is layered on the cleared values.
    always_comb begin
        sb_base   = clr_i ? '0 : sb_cnt_q;
        db_base   = clr_i ? '0 : db_cnt_q;
        fix_base  = clr_i ? '0 : fix_cnt_q;
        st_base   = clr_i ? ST_CLEAN : state_q;
        sb_cnt_d  = sat_inc(sb_base, sb_ev);
        db_cnt_d  = sat_inc(db_base, db_ev);
        fix_cnt_d = sat_inc(fix_base, fix_ev);
        state_d   = st_base;
        if (db_ev) begin
            state_d = ST_FATAL;
        end else if (sb_ev) begin
            case (st_base)
                ST_CLEAN, ST_CORR: state_d = (sb_cnt_d >= THR) ? ST_THRESH : ST_CORR;
                ST_THRESH:         state_d = ST_THRESH;
                default:           state_d = ST_FATAL;
            endcase
        end
    end

    // Health FSM, counters and the registered alarm advance only on enabled cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_CLEAN;
            irq_q     <= 1'b0;
            sb_cnt_q  <= '0;
            db_cnt_q  <= '0;
            fix_cnt_q <= '0;
        end else if (clkena_i) begin
            state_q   <= state_d;
            irq_q     <= (state_d == ST_THRESH) || (state_d == ST_FATAL);
            sb_cnt_q  <= sb_cnt_d;
            db_cnt_q  <= db_cnt_d;
            fix_cnt_q <= fix_cnt_d;
        end
    end

    assign sb_cnt_o  = sb_cnt_q;
    assign db_cnt_o  = db_cnt_q;
    assign fix_cnt_o = fix_cnt_q;
    assign state_o   = state_q;
    assign irq_o     = irq_q;

`ifdef ECC_ERR_MONITOR_SYNLOG_EN
    logic          syn_vld_q, syn_vld_d, vld_base;
    logic [SW-1:0] syn_first_q, syn_first_d;
    logic [SW-1:0] syn_last_q, syn_last_d;

    // First syndrome is latched once per reset/clear epoch; last is refreshed on every event.
    always_comb begin
        vld_base    = clr_i ? 1'b0 : syn_vld_q;
        syn_vld_d   = vld_base;
        syn_first_d = syn_first_q;
        syn_last_d  = syn_last_q;
        if (err_ev) begin
            if (!vld_base) begin
                syn_first_d = syndrome_i;
            end
            syn_vld_d  = 1'b1;
            syn_last_d = syndrome_i;
        end
    end

    // Syndrome log registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syn_vld_q   <= 1'b0;
            syn_first_q <= '0;
            syn_last_q  <= '0;
        end else if (clkena_i) begin
            syn_vld_q   <= syn_vld_d;
            syn_first_q <= syn_first_d;
            syn_last_q  <= syn_last_d;
        end
    end

    assign syn_vld_o   = syn_vld_q;
    assign syn_first_o = syn_first_q;
    assign syn_last_o  = syn_last_q;
`else
    // Logging not built: outputs tied off, syndrome input intentionally unused.
    logic syn_unused;
    assign syn_unused  = ^{syndrome_i, err_ev};
    assign syn_vld_o   = 1'b0;
    assign syn_first_o = '0;
    assign syn_last_o  = '0;
`endif

endmodule

// File: tb/tb_ecc_err_monitor.sv
// Bench for ecc_err_monitor: two instances (default widths, and CNT_W=4 / SB_THRESH=3) against an integer model.
// Latency: outputs checked 1 time unit after each rising edge; reset checked between edges.
// Directed steps followed by randomized traffic including clears, clock-enable gaps and a mid-run reset.
module tb_ecc_err_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clkena, valid, sb_err, db_err, sb_fix, clr;
    logic [7:0] syn;

    logic [15:0] sb0, db0, fix0;
    logic [1:0]  st0;
    logic        irq0, sv0;
    logic [7:0]  sf0, sl0;
    logic [3:0]  sb1, db1, fix1;
    logic [1:0]  st1;
    logic        irq1, sv1;
    logic [7:0]  sf1, sl1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance (index 0: CNT_W=16/THR=16, index 1: CNT_W=4/THR=3).
    int m_sb[2], m_db[2], m_fix[2], m_st[2], m_vld[2], m_first[2], m_last[2];
    int MAXV[2] = '{65535, 15};
    int THR[2]  = '{16, 3};

    always #5 clk = ~clk;

    ecc_err_monitor #(.SW(8), .CNT_W(16), .SB_THRESH(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .valid_i(valid),
        .sb_err_i(sb_err), .db_err_i(db_err), .sb_fix_i(sb_fix), .syndrome_i(syn), .clr_i(clr),
        .sb_cnt_o(sb0), .db_cnt_o(db0), .fix_cnt_o(fix0), .state_o(st0), .irq_o(irq0),
        .syn_vld_o(sv0), .syn_first_o(sf0), .syn_last_o(sl0)
    );

    ecc_err_monitor #(.SW(8), .CNT_W(4), .SB_THRESH(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .valid_i(valid),
        .sb_err_i(sb_err), .db_err_i(db_err), .sb_fix_i(sb_fix), .syndrome_i(syn), .clr_i(clr),
        .sb_cnt_o(sb1), .db_cnt_o(db1), .fix_cnt_o(fix1), .state_o(st1), .irq_o(irq1),
        .syn_vld_o(sv1), .syn_first_o(sf1), .syn_last_o(sl1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sb[k] = 0; m_db[k] = 0; m_fix[k] = 0; m_st[k] = 0;
            m_vld[k] = 0; m_first[k] = 0; m_last[k] = 0;
        end
    endtask

    function automatic int sat1(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (clkena) begin
                if (clr) begin
                    m_sb[k] = 0; m_db[k] = 0; m_fix[k] = 0; m_st[k] = 0; m_vld[k] = 0;
                end
                if (valid && (sb_err || db_err)) begin
                    if (db_err) begin
                        m_db[k] = sat1(m_db[k], MAXV[k]);
                        m_st[k] = 3;
                    end else begin
                        m_sb[k] = sat1(m_sb[k], MAXV[k]);
                        if (sb_fix) m_fix[k] = sat1(m_fix[k], MAXV[k]);
                        if (m_st[k] != 3) m_st[k] = (m_sb[k] >= THR[k]) ? 2 : 1;
                    end
`ifdef ECC_ERR_MONITOR_SYNLOG_EN
                    if (m_vld[k] == 0) m_first[k] = int'(syn);
                    m_vld[k] = 1;
                    m_last[k] = int'(syn);
`endif
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/sb0"},  32'(sb0),  32'(m_sb[0]));
        chk({tag, "/db0"},  32'(db0),  32'(m_db[0]));
        chk({tag, "/fix0"}, 32'(fix0), 32'(m_fix[0]));
        chk({tag, "/st0"},  32'(st0),  32'(m_st[0]));
        chk({tag, "/irq0"}, 32'(irq0), 32'(m_st[0] >= 2));
        chk({tag, "/sv0"},  32'(sv0),  32'(m_vld[0]));
        chk({tag, "/sf0"},  32'(sf0),  32'(m_first[0]));
        chk({tag, "/sl0"},  32'(sl0),  32'(m_last[0]));
        chk({tag, "/sb1"},  32'(sb1),  32'(m_sb[1]));
        chk({tag, "/db1"},  32'(db1),  32'(m_db[1]));
        chk({tag, "/fix1"}, 32'(fix1), 32'(m_fix[1]));
        chk({tag, "/st1"},  32'(st1),  32'(m_st[1]));
        chk({tag, "/irq1"}, 32'(irq1), 32'(m_st[1] >= 2));
        chk({tag, "/sv1"},  32'(sv1),  32'(m_vld[1]));
        chk({tag, "/sf1"},  32'(sf1),  32'(m_first[1]));
        chk({tag, "/sl1"},  32'(sl1),  32'(m_last[1]));
    endtask

    task automatic drive(input logic en, input logic v, input logic s, input logic d,
                         input logic f, input logic [7:0] sy, input logic c);
        clkena = en; valid = v; sb_err = s; db_err = d; sb_fix = f; syn = sy; clr = c;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        #20 rst_n = 1'b1;

        // Idle valid cycles: nothing counts.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 1'b0);
            step("idle");
        end

        // 16 repaired single-bit events walk the default instance to THRESH.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
            step("sb_run");
            if (i == 15) begin
                chk("sb15_cnt", 32'(sb0), 32'd15);
                chk("sb15_st", 32'(st0), 32'd1);
                chk("sb15_irq", 32'(irq0), 32'd0);
            end
            if (i == 16) begin
                chk("sb16_cnt", 32'(sb0), 32'd16);
                chk("sb16_fix", 32'(fix0), 32'd16);
                chk("sb16_st", 32'(st0), 32'd2);
                chk("sb16_irq", 32'(irq0), 32'd1);
            end
        end

        // Clear alone, then both flags together with syndrome 0x5A.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step("clr");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
        step("sbdb");
        chk("sbdb_db", 32'(db0), 32'd1);
        chk("sbdb_sb", 32'(sb0), 32'd0);
        chk("sbdb_st", 32'(st0), 32'd3);
        chk("sbdb_irq", 32'(irq0), 32'd1);
`ifdef ECC_ERR_MONITOR_SYNLOG_EN
        chk("sbdb_first", 32'(sf0), 32'h5A);
`else
        chk("sbdb_first", 32'(sf0), 32'h00);
`endif

        // 20 double-bit events saturate the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
            step("db_run");
        end
        chk("dbsat_cnt", 32'(db1), 32'd15);
        chk("dbsat_st", 32'(st1), 32'd3);

        // Clear together with a single-bit event: clear first, then the event.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 1'b1);
        step("clr_sb");
        chk("clrsb_db", 32'(db1), 32'd0);
        chk("clrsb_sb", 32'(sb1), 32'd1);
        chk("clrsb_st", 32'(st1), 32'd1);
        chk("clrsb_irq", 32'(irq1), 32'd0);

        // Clock enable low: events and clears are ignored.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
            step("noena");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step("noena_clr");
        chk("noena_sb", 32'(sb0), 32'd1);

        // Events carrying syndrome 0x33.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
            step("syn33");
        end

        // Randomized traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 59) == 0));
            step("rand");
            if (i == 300) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all("midreset");
                #2 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_err_monitor.md
ECC_ERR_MONITOR -- requirements
Module: ecc_err_monitor

Interface
REQ-001 SHALL have parameter SW, default 8: syndrome width, equal to the decoder syndrome_o width.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL have parameter SB_THRESH, default 16: single-bit error count that raises the threshold alarm; legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk_i, input, 1: clock, rising-edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port clkena_i, input, 1: clock enable; when low, no register changes.
REQ-007 SHALL have port valid_i, input, 1: decoder flags and syndrome are valid this cycle.
REQ-008 SHALL have port sb_err_i, input, 1: decoder single-bit error flag.
REQ-009 SHALL have port db_err_i, input, 1: decoder double-bit error flag.
REQ-010 SHALL have port sb_fix_i, input, 1: decoder repaired an information bit.
REQ-011 SHALL have port syndrome_i, input, SW: decoder syndrome.
REQ-012 SHALL have port clr_i, input, 1: synchronous clear request, one-cycle pulse.
REQ-013 SHALL have port sb_cnt_o, output, CNT_W: single-bit error count.
REQ-014 SHALL have port db_cnt_o, output, CNT_W: double-bit error count.
REQ-015 SHALL have port fix_cnt_o, output, CNT_W: repaired-data-bit count.
REQ-016 SHALL have port state_o, output, 2: 0=CLEAN, 1=CORRECTED, 2=THRESH, 3=FATAL.
REQ-017 SHALL have port irq_o, output, 1: alarm, level-high.
REQ-018 SHALL have port syn_vld_o, output, 1: syn_first_o is valid.
REQ-019 SHALL have ports syn_first_o and syn_last_o, output, SW each: syndromes of the first and most recent logged error.

Function
REQ-020 SHALL sample an event only when clkena_i=1 and valid_i=1. All outputs are registered; each event appears on the outputs exactly 1 cycle after it is sampled.
REQ-021 SHALL treat sb_err_i=1 and db_err_i=1 in the same cycle as a double-bit event only; sb_cnt_o is not incremented.
REQ-022 SHALL increment each counter by 1 per qualifying event and saturate at 2^CNT_W-1 with no wrap.
REQ-023 SHALL count sb_fix_i only when it is qualified by sb_err_i=1 and db_err_i=0.
REQ-024 SHALL use the following FSM transitions:
- CLEAN->CORRECTED on a single-bit event.
- CORRECTED->THRESH when the incremented sb count is >= SB_THRESH.
- CLEAN->THRESH directly if SB_THRESH=1.
- Any state->FATAL on a double-bit event.
- FATAL is left only by clr_i.
REQ-025 SHALL drive irq_o=1 in THRESH or FATAL and irq_o=0 otherwise.
REQ-026 On clr_i=1 with clkena_i=1, SHALL zero all counters, return to CLEAN, and clear syn_vld_o.
REQ-027 If clr_i and an event occur in the same cycle, SHALL apply the clear first and then the event. Example: sb event gives sb_cnt_o=1 and state CORRECTED.
REQ-028 SHALL ignore clr_i when clkena_i=0.

Reset
REQ-029 While rst_ni=0, SHALL asynchronously force all counters to 0, state_o=CLEAN, irq_o=0, syn_vld_o=0, and syn_first_o=syn_last_o=0.
REQ-030 SHALL release reset synchronously with the next enabled clk_i edge. Reset asserted mid-operation discards all logged state.

Configuration
REQ-031 With macro ECC_ERR_MONITOR_SYNLOG_EN defined, SHALL implement syndrome logging:
- syn_first_o captures syndrome_i on the first event after reset or clear, and syn_vld_o goes to 1.
- syn_last_o captures syndrome_i on every event.
REQ-032 Without ECC_ERR_MONITOR_SYNLOG_EN, SHALL tie syn_vld_o, syn_first_o and syn_last_o to 0 and instantiate no syndrome registers.

Verification
REQ-033 Reset, then 20 valid cycles with no flags -> all counters 0, state_o=0, irq_o=0.
REQ-034 SB_THRESH=16, 16 single-bit events with sb_fix_i=1 -> after the 15th: sb_cnt_o=15, state_o=1, irq_o=0; after the 16th: sb_cnt_o=16, fix_cnt_o=16, state_o=2, irq_o=1.
REQ-035 A single cycle with sb_err_i=db_err_i=1, syndrome_i=0x5A -> db_cnt_o=1, sb_cnt_o=0, state_o=3, irq_o=1, syn_first_o=0x5A (SYNLOG_EN defined).
REQ-036 CNT_W=4, 20 double-bit events -> db_cnt_o=15, state_o=3. Then clr_i together with a single-bit event -> db_cnt_o=0, sb_cnt_o=1, state_o=1, irq_o=0.
REQ-037 clkena_i=0 with valid_i=1, sb_err_i=1 for 5 cycles -> no change. rst_ni pulsed low mid-stream -> outputs 0 immediately, without waiting for a clock edge.
REQ-038 Build without ECC_ERR_MONITOR_SYNLOG_EN, events with syndrome_i=0x33 -> syn_vld_o=0, syn_first_o=0, syn_last_o=0; counters unaffected.
